config_chain_loader: RTL and testbench
======================================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bitstream word width in bits.
REQ-002 SHALL have parameter CHAIN_LEN, default 1024, total configuration-chain length in bits; legal range 1..65535.
REQ-003 SHALL have parameter CNT_W, default 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.
REQ-004 SHALL have port prog_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a chain load.
REQ-007 SHALL have port abort  in  1  synchronous abandon of the load in progress.
REQ-008 SHALL have port bs_data  in  WORD_W  bitstream word, MSB shifted first.
REQ-009 SHALL have port bs_valid  in  1  bs_data is valid.
REQ-010 SHALL have port bs_ready  out  1  loader accepts bs_data this cycle.
REQ-011 SHALL have port sc_head_out  out  1  serial data into the chain head, feeding sc_head_N_in of the first tile.
REQ-012 SHALL have port sc_shift_en  out  1  chain shift qualifier for prog_clk gating; high exactly on cycles where sc_head_out carries a valid bit.
REQ-013 SHALL have port config_enable  out  1  high from SHIFT entry until DONE, feeding config_enable_N_in.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE and DONE.
REQ-015 SHALL have port done  out  1  chain fully loaded.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, DONE, with every output driven combinationally from state or directly from flops, with no input-to-output combinational path except bs_ready.
REQ-017 SHALL move from IDLE or DONE to LOAD, clearing the bit counter and done, when start=1; start SHALL be ignored in LOAD and SHIFT.
REQ-018 SHALL drive bs_ready=1 throughout LOAD; a handshake (bs_valid & bs_ready) SHALL capture bs_data into the shift register and enter SHIFT next cycle.
REQ-019 SHALL, in SHIFT, set sc_head_out = shift-register MSB and sc_shift_en=1, shift left by one each cycle, and increment the bit counter by 1.
REQ-020 SHALL drive bs_ready=1 in SHIFT only on the last bit of the current word and only when bits remain after it, so that a handshake there continues SHIFT gaplessly with the new word.
REQ-021 SHALL, on the last bit of a word with no handshake and bits remaining, enter LOAD; sc_shift_en SHALL be 0 while stalled, and config_enable SHALL stay 1.
REQ-022 SHALL, when the bit counter reaches CHAIN_LEN, enter DONE next cycle with done=1, config_enable=0 and sc_shift_en=0; done SHALL hold until start, abort or reset.
REQ-023 SHALL, when CHAIN_LEN is not a multiple of WORD_W, shift only the top (CHAIN_LEN mod WORD_W) bits of the final word and discard its remainder.
REQ-024 SHALL, on abort=1 in any state, go to IDLE next cycle with all outputs at their reset values; abort SHALL take priority over start and over a handshake in the same cycle.
REQ-025 SHALL never shift more than CHAIN_LEN bits per load.

Reset
REQ-026 SHALL, when reset=1, enter IDLE and clear the shift register and the bit counter.
REQ-027 SHALL hold all outputs at 0 during and after reset, and reset SHALL take priority over abort, start and a handshake.
REQ-028 SHALL abandon any partial load on reset mid-operation, with no further sc_shift_en pulses until a new start.

Verification
REQ-029 SHALL pass this case (WORD_W=8, CHAIN_LEN=16): start at cycle 0, words 0xA5 then 0x3C valid continuously -> bs_ready at cycle 1 and handshake at cycle 1; sc_head_out = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on cycles 2..17 with sc_shift_en=1 and no gap; done=1 at cycle 18.
REQ-030 SHALL pass this case (CHAIN_LEN=20): three words 0xFF, 0x00, 0xF0 -> exactly 20 sc_shift_en pulses, last four bits 1,1,1,1, and the low nibble of 0xF0 never appears.
REQ-031 SHALL pass this stall case: bs_valid held low for 3 cycles after the first word -> sc_shift_en=0 for exactly those cycles, config_enable stays 1, and the bit count is unchanged.
REQ-032 SHALL pass this case: abort asserted together with a handshake mid-SHIFT -> IDLE next cycle, word not captured, and all outputs 0.
REQ-033 SHALL pass this case: reset asserted during SHIFT at bit 5 -> outputs 0 next cycle, and a following start reloads from bit 0 with the counter at 0.
REQ-034 SHALL pass this case: start held high during SHIFT -> no effect; after DONE, start restarts the load and done clears the next cycle.

Source files
------------

// File: rtl/config_chain_loader.sv
// Configuration-chain loader: takes bitstream words over a ready/valid port and
// shifts them MSB-first into a serial configuration chain of CHAIN_LEN bits.
module config_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              sc_head_out,
  output logic              sc_shift_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_d;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              in_shift;
  logic              last_chain_bit;
  logic              last_word_bit;
  logic              capture;
  logic              clear_cnt;
  logic              advance;

  assign in_shift       = (state == SHIFT);
  assign last_chain_bit = (bit_cnt == LAST_BIT);
  assign last_word_bit  = (bit_idx == LAST_IDX);
  assign advance        = in_shift && !abort;

  // The chain-length limit ends the load even mid-word, which drops the unused
  // low bits of a final partial word and keeps bs_ready low on that bit.
  assign bs_ready      = (state == LOAD) || (in_shift && last_word_bit && !last_chain_bit);
  assign sc_shift_en   = in_shift;
  assign sc_head_out   = in_shift && shift_reg[WORD_W-1];
  // A nonzero count in LOAD means a mid-chain stall, where the chain stays enabled.
  assign config_enable = in_shift || ((state == LOAD) && (bit_cnt != '0));
  assign busy          = (state == LOAD) || in_shift;
  assign done          = (state == DONE);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state;
    capture   = 1'b0;
    clear_cnt = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      clear_cnt = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_d   = LOAD;
            clear_cnt = 1'b1;
          end
        end
        LOAD: begin
          if (bs_valid) begin
            capture = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last_chain_bit) begin
            state_d = DONE;
          end else if (last_word_bit) begin
            if (bs_valid) capture = 1'b1;
            else          state_d = LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state     <= IDLE;
      // NOTE: the word register is cleared on reset because a partial load must
      // never resurface; it is a handful of flops, not a memory array.
      shift_reg <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_d;

      if (clear_cnt)    bit_cnt <= '0;
      else if (advance) bit_cnt <= bit_cnt + 1'b1;

      if (capture) begin
        shift_reg <= bs_data;
        bit_idx   <= '0;
      end else if (advance) begin
        shift_reg <= shift_reg << 1;
        bit_idx   <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a cycle table for the basic two-word
// load plus hand-written sequences for partial words, stalls, abort and reset.
module tb_config_chain_loader;

  logic       prog_clk = 1'b0;
  logic       reset;
  logic       start, abort, bs_valid;
  logic [7:0] bs_data;
  logic       bs_ready, sc_head_out, sc_shift_en, config_enable, busy, done;

  logic       start20, abort20, valid20;
  logic [7:0] data20;
  logic       ready20, head20, sen20, cfg20, busy20, done20;

  logic [5:0] outs16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 prog_clk = ~prog_clk;

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) dut16 (
    .prog_clk     (prog_clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .sc_head_out  (sc_head_out),
    .sc_shift_en  (sc_shift_en),
    .config_enable(config_enable),
    .busy         (busy),
    .done         (done)
  );

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dut20 (
    .prog_clk     (prog_clk),
    .reset        (reset),
    .start        (start20),
    .abort        (abort20),
    .bs_data      (data20),
    .bs_valid     (valid20),
    .bs_ready     (ready20),
    .sc_head_out  (head20),
    .sc_shift_en  (sen20),
    .config_enable(cfg20),
    .busy         (busy20),
    .done         (done20)
  );

  // Output vector order: bs_ready, sc_head_out, sc_shift_en, config_enable, busy, done
  assign outs16 = {bs_ready, sc_head_out, sc_shift_en, config_enable, busy, done};

  typedef struct {
    logic       st;
    logic       ab;
    logic       vld;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then let outputs settle.
  task automatic step(input logic st, input logic ab, input logic vld, input logic [7:0] d);
    @(negedge prog_clk);
    start    = st;
    abort    = ab;
    bs_valid = vld;
    bs_data  = d;
    #1;
  endtask

  task automatic step20(input logic st, input logic vld, input logic [7:0] d);
    @(negedge prog_clk);
    start20 = st;
    valid20 = vld;
    data20  = d;
    #1;
  endtask

  // Shift n bits of word w, checking each cycle; bs_ready is expected on bit 7
  // only when rdy_last says more chain bits follow this word.
  task automatic shift_bits(input logic [7:0] w, input int n, input logic st, input logic vld,
                            input logic [7:0] d, input logic rdy_last, input string tag);
    logic [5:0] exp;
    for (int k = 0; k < n; k++) begin
      step(st, 1'b0, vld, d);
      exp = {((k == 7) && rdy_last), w[7-k], 4'b1110};
      check($sformatf("%s bit%0d", tag, k), outs16, exp);
    end
  endtask

  task automatic back_to_idle(input string tag);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check({tag, " idle"}, outs16, 6'b000000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wa, wb;
    logic [7:0] words20 [3];
    logic [19:0] bits20;
    int w, pulses;

    wa = 8'hA5;
    wb = 8'h3C;
    words20[0] = 8'hFF;
    words20[1] = 8'h00;
    words20[2] = 8'hF0;

    // Two-word load on the 16-bit chain, one entry per cycle.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b000000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, wa,    6'b100010};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{1'b0, 1'b0, 1'b1, wb, {(k == 7), wa[7-k], 4'b1110}};
    for (int k = 0; k < 8; k++)
      tbl[10+k] = '{1'b0, 1'b0, 1'b1, wb, {1'b0, wb[7-k], 4'b1110}};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000001};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000001};

    reset   = 1'b1;
    start   = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = 8'h00;
    start20 = 1'b0; abort20 = 1'b0; valid20 = 1'b0; data20 = 8'h00;

    // Reset state, including with start/valid asserted during reset.
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    check("in reset outputs", outs16, 6'b000000);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("after reset outputs", outs16, 6'b000000);
    check("after reset count", dut16.bit_cnt, 32'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].vld, tbl[i].data);
      check($sformatf("two_word c%0d", i), outs16, tbl[i].exp);
    end

    // Abort beats start in DONE.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("abort+start in done", outs16, 6'b000001);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("abort beats start", outs16, 6'b000000);

    // start held high through the whole load, then restart from DONE.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("held start c0", outs16, 6'b000000);
    step(1'b1, 1'b0, 1'b1, wa);
    check("held start load", outs16, 6'b100010);
    shift_bits(wa, 8, 1'b1, 1'b1, wb, 1'b1, "held start w0");
    shift_bits(wb, 8, 1'b1, 1'b1, 8'h55, 1'b0, "held start w1");
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("held start done", outs16, 6'b000001);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("restart clears done", outs16, 6'b100010);
    back_to_idle("restart");

    // Stall: no word offered for the three cycles after the first word.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, wa);
    check("stall load", outs16, 6'b100010);
    shift_bits(wa, 8, 1'b0, 1'b0, 8'h00, 1'b1, "stall w0");
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("stall c1", outs16, 6'b100110);
    check("stall c1 count", dut16.bit_cnt, 32'd8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("stall c2", outs16, 6'b100110);
    step(1'b0, 1'b0, 1'b1, wb);
    check("stall c3", outs16, 6'b100110);
    check("stall c3 count", dut16.bit_cnt, 32'd8);
    shift_bits(wb, 8, 1'b0, 1'b0, 8'h00, 1'b0, "stall w1");
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("stall done", outs16, 6'b000001);
    back_to_idle("stall");

    // Abort together with a handshake on the last bit of the first word.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, wa);
    shift_bits(wa, 7, 1'b0, 1'b0, 8'h00, 1'b1, "abort w0");
    step(1'b0, 1'b1, 1'b1, wb);
    check("abort cycle", outs16, 6'b111110);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("after abort outputs", outs16, 6'b000000);
    check("abort word not captured", (dut16.shift_reg == wb), 32'd0);
    step(1'b0, 1'b0, 1'b1, wb);
    check("idle ignores valid", outs16, 6'b000000);

    // Reset at bit 5, then a clean reload from bit 0.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, wa);
    shift_bits(wa, 5, 1'b0, 1'b0, 8'h00, 1'b1, "reset w0");
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("reset at bit5", outs16, 6'b011110);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("reset mid shift outputs", outs16, 6'b000000);
    check("reset mid shift count", dut16.bit_cnt, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("post reset quiet %0d", k), outs16, 6'b000000);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, wb);
    check("reload load", outs16, 6'b100010);
    check("reload count", dut16.bit_cnt, 32'd0);
    shift_bits(wb, 3, 1'b0, 1'b0, 8'h00, 1'b0, "reload w0");
    back_to_idle("reload");

    // 20-bit chain: third word contributes only its top nibble.
    w      = 0;
    pulses = 0;
    bits20 = '0;
    step20(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 40 && !done20; c++) begin
      if (w < 3) step20(1'b0, 1'b1, words20[w]);
      else       step20(1'b0, 1'b0, 8'h00);
      if (sen20) begin
        bits20 = {bits20[18:0], head20};
        pulses++;
      end
      if (ready20 && valid20) w++;
    end
    check("partial done", done20, 32'd1);
    check("partial pulses", pulses, 32'd20);
    check("partial bits", bits20, 32'hFF00F);
    check("partial words taken", w, 32'd3);
    check("partial done outputs", {ready20, head20, sen20, cfg20, busy20}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
